uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//  Parametrised UART receiver: next generation of the Basys3 serial RX path.
//  - Configurable data width, parity mode and stop-bit count; 3-sample majority vote at mid-bit.
//  - Parity, framing and break detection, reported alongside a one-cycle data-valid strobe.
//  - Sits between the board RX pin and the byte-consumer logic, in the single system clock domain.
// PARAMETERS
//  CLKS_PER_BIT  10416  clocks per bit (100 MHz / 9600 baud); legal >= 8
//  DATA_BITS     8      data bits per frame, legal 5..9, LSB first
//  PARITY        0      0 = none, 1 = odd, 2 = even
//  STOP_BITS     1      1 or 2
//  CNT_W         $clog2(CLKS_PER_BIT)  derived counter width; never overridden
// PORTS
//  i_Clock       in   1          system clock, all logic on rising edge
//  i_Rst_n       in   1          asynchronous active-low reset
//  i_Rx_Serial   in   1          raw serial line, idle high, asynchronous to i_Clock
//  o_Rx_DV       out  1          one-cycle pulse: o_Rx_Byte and flags are valid
//  o_Rx_Byte     out  DATA_BITS  received data, held until the next o_Rx_DV
//  o_Parity_Err  out  1          parity mismatch for this frame; valid with o_Rx_DV; 0 when PARITY = 0
//  o_Frame_Err   out  1          a stop bit was sampled low; valid with o_Rx_DV
//  o_Break       out  1          one-cycle pulse: break detected; o_Rx_DV is not asserted for it
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - Synchroniser flops = 1; state = IDLE; counters = 0.
//   - o_Rx_DV = 0, o_Rx_Byte = 0, o_Parity_Err = 0, o_Frame_Err = 0, o_Break = 0.
//   - Reset mid-frame aborts the frame immediately; no o_Rx_DV follows.
//  Input conditioning
//   - 2-flop synchroniser, then a 3-bit history shift register of synced samples.
//   - Bit value = majority of the 3 most recent samples, evaluated at each sample point.
//  Timing
//   - Bit counter is CNT_W wide.
//   - Start-bit sample point: (CLKS_PER_BIT-1)/2 clocks after IDLE sees the synced line low.
//   - Each later sample point: exactly CLKS_PER_BIT clocks after the previous one.
//  States
//   - IDLE: synced line = 0 -> START.
//   - START: at sample point, vote = 0 -> DATA; vote = 1 -> IDLE (glitch reject, no flags).
//   - DATA: store vote into bit index 0..DATA_BITS-1; after the last bit -> PARITY if PARITY != 0, else STOP.
//   - PARITY: sample the parity bit.
//       - Odd:  error if XOR(data, parity bit) = 0.
//       - Even: error if XOR(data, parity bit) = 1.
//   - STOP: sample STOP_BITS stop bits; o_Frame_Err = 1 if any stop bit votes 0.
//   - At the final stop sample point:
//       - Break: all data = 0, parity bit (if present) = 0, first stop bit = 0. Pulse o_Break for one
//         cycle, no o_Rx_DV, o_Rx_Byte unchanged -> WAIT_HIGH.
//       - Otherwise: in the same cycle, latch o_Rx_Byte and both error flags and pulse o_Rx_DV.
//         Frame error -> WAIT_HIGH, else -> IDLE.
//   - WAIT_HIGH: stay until synced line = 1, then -> IDLE. Prevents a re-trigger on a stuck-low line.
//   - Undefined state encodings -> IDLE.
//  Latency and flags
//   - o_Rx_DV fires at the mid-point of the last stop bit, i.e. about half a bit before frame end.
//   - A back-to-back next start bit is therefore caught from IDLE.
//   - Error flags stay held until the next o_Rx_DV.
// TESTING (sim with CLKS_PER_BIT = 16)
//  1. 8N1, send 0xA5 -> one o_Rx_DV pulse, o_Rx_Byte = 0xA5, both error flags 0.
//  2. 8E1, send 0x07 with parity bit 0 (wrong) -> o_Rx_DV pulse, o_Rx_Byte = 0x07, o_Parity_Err = 1.
//  3. 8N2, send 0x3C with the second stop bit low -> o_Rx_DV, o_Frame_Err = 1; no new frame until line high.
//  4. Hold line low for 12 bit-times -> one o_Break pulse, no o_Rx_DV; line high, then 0x55 -> received OK.
//  5. 6-clock low glitch on an idle line, plus one flipped sample per bit of 0x81 -> glitch ignored, 0x81 received.
//  6. Assert i_Rst_n mid-DATA, release, send 0x12 -> outputs at reset values, then 0x12 received cleanly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with 3-sample majority vote at mid-bit,
// parity / framing / break detection and a one-cycle data-valid strobe.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break
);

  localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StParity   = 3'd3,
    StStop     = 3'd4,
    StWaitHigh = 3'd5
  } state_t;

  state_t               state;
  logic                 sync1, sync2;
  logic [2:0]           hist;
  logic                 vote;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] data_sh;
  logic                 par_bit;
  logic                 stop_first;
  logic                 stop_err;
  logic                 par_err_calc;
  logic                 frame_err_now;
  logic                 first_stop_now;
  logic                 is_break;

  // Two-flop synchroniser and 3-deep history of synced samples; all reset to idle-high.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= 3'b111;
    end else begin
      sync1 <= i_Rx_Serial;
      sync2 <= sync1;
      hist  <= {hist[1:0], sync2};
    end
  end

  assign vote = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

  // Frame checks evaluated at the final stop sample point.
  always_comb begin
    par_err_calc = 1'b0;
    if (PARITY == 1) begin
      par_err_calc = ~(^{data_sh, par_bit});
    end else if (PARITY == 2) begin
      par_err_calc = ^{data_sh, par_bit};
    end
    frame_err_now  = stop_err | ~vote;
    first_stop_now = (stop_idx == 1'b0) ? vote : stop_first;
    is_break       = (data_sh == '0) && ((PARITY == 0) || !par_bit) && !first_stop_now;
  end

  // Receive FSM; all outputs registered, DV and break are single-cycle pulses.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state        <= StIdle;
      cnt          <= '0;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      data_sh      <= '0;
      par_bit      <= 1'b0;
      stop_first   <= 1'b1;
      stop_err     <= 1'b0;
      o_Rx_DV      <= 1'b0;
      o_Rx_Byte    <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Break      <= 1'b0;
    end else begin
      o_Rx_DV <= 1'b0;
      o_Break <= 1'b0;
      case (state)
        StIdle: begin
          if (!sync2) begin
            state <= StStart;
            cnt   <= '0;
          end
        end
        StStart: begin
          // Counted from the first cycle spent in START; a low glitch shorter than
          // the vote window's lead-in is voted out here.
          if (cnt == HALF_CNT) begin
            cnt <= '0;
            if (!vote) begin
              state   <= StData;
              bit_idx <= '0;
            end else begin
              state <= StIdle;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StData: begin
          if (cnt == FULL_CNT) begin
            cnt     <= '0;
            // LSB arrives first, so shifting in from the top leaves it in bit 0.
            data_sh <= {vote, data_sh[DATA_BITS-1:1]};
            if (bit_idx == LAST_DATA) begin
              bit_idx  <= '0;
              stop_idx <= 1'b0;
              stop_err <= 1'b0;
              state    <= (PARITY != 0) ? StParity : StStop;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StParity: begin
          if (cnt == FULL_CNT) begin
            cnt     <= '0;
            par_bit <= vote;
            state   <= StStop;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StStop: begin
          if (cnt == FULL_CNT) begin
            cnt <= '0;
            if (stop_idx == LAST_STOP) begin
              if (is_break) begin
                o_Break <= 1'b1;
                state   <= StWaitHigh;
              end else begin
                o_Rx_DV      <= 1'b1;
                o_Rx_Byte    <= data_sh;
                o_Parity_Err <= par_err_calc;
                o_Frame_Err  <= frame_err_now;
                state        <= frame_err_now ? StWaitHigh : StIdle;
              end
            end else begin
              stop_first <= vote;
              stop_err   <= stop_err | ~vote;
              stop_idx   <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StWaitHigh: begin
          // Hold off until the line returns high so a stuck-low line cannot re-trigger.
          if (sync2) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8N1, 8E1, 8N2) at 16 clocks per bit,
// directed scenarios followed by randomized frames checked against a frame-level model.
module tb_uart_rx_cfg;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] rx;
  logic [2:0] dv, pe, fe, brk;
  logic [7:0] rxb [3];

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx[0]), .o_Rx_DV(dv[0]),
    .o_Rx_Byte(rxb[0]), .o_Parity_Err(pe[0]), .o_Frame_Err(fe[0]), .o_Break(brk[0]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx[1]), .o_Rx_DV(dv[1]),
    .o_Rx_Byte(rxb[1]), .o_Parity_Err(pe[1]), .o_Frame_Err(fe[1]), .o_Break(brk[1]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx[2]), .o_Rx_DV(dv[2]),
    .o_Rx_Byte(rxb[2]), .o_Parity_Err(pe[2]), .o_Frame_Err(fe[2]), .o_Break(brk[2]));

  typedef struct packed {
    logic [7:0] b;
    logic       pe;
    logic       fe;
  } rec_t;

  rec_t       q0[$], q1[$], q2[$];
  int         brk_cnt [3];
  logic [7:0] exp_last [3];
  int         tests = 0;
  int         fails = 0;

  // Record every DV pulse and break pulse, sampled away from the rising edge.
  always @(negedge clk) begin
    if (dv[0]) q0.push_back({rxb[0], pe[0], fe[0]});
    if (dv[1]) q1.push_back({rxb[1], pe[1], fe[1]});
    if (dv[2]) q2.push_back({rxb[2], pe[2], fe[2]});
    for (int k = 0; k < 3; k++) if (brk[k]) brk_cnt[k]++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int ch);
    case (ch)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic pop(input int ch, output rec_t r, output bit ok);
    ok = 1'b0;
    r  = '0;
    case (ch)
      0:       if (q0.size() > 0) begin r = q0.pop_front(); ok = 1'b1; end
      1:       if (q1.size() > 0) begin r = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin r = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // One bit time on channel ch; optional single-clock inversion near mid-bit.
  task automatic drive_bit(input int ch, input logic v, input bit flip);
    rx[ch] = v;
    repeat (7) @(negedge clk);
    if (flip) rx[ch] = ~v;
    @(negedge clk);
    rx[ch] = v;
    repeat (CPB - 8) @(negedge clk);
  endtask

  // Channel 0 = 8N1, 1 = 8E1, 2 = 8N2.
  task automatic send_frame(input int ch, input logic [7:0] d, input logic pbit,
                            input logic [1:0] stops, input bit flip);
    drive_bit(ch, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(ch, d[i], flip);
    if (ch == 1) drive_bit(ch, pbit, 1'b0);
    drive_bit(ch, stops[0], 1'b0);
    if (ch == 2) drive_bit(ch, stops[1], 1'b0);
  endtask

  task automatic idle(input int ch, input int nbits);
    rx[ch] = 1'b1;
    repeat (nbits * CPB) @(negedge clk);
  endtask

  // Frame-level reference: what the receiver should report for one frame.
  function automatic rec_t model(input int ch, input logic [7:0] d, input logic pbit,
                                 input logic [1:0] stops, output bit is_brk);
    rec_t r;
    r.b    = d;
    r.pe   = (ch == 1) ? ((($countones(d) + int'(pbit)) % 2) == 1) : 1'b0;
    r.fe   = !stops[0] || ((ch == 2) && !stops[1]);
    is_brk = (d == 8'h00) && ((ch != 1) || !pbit) && !stops[0];
    return r;
  endfunction

  task automatic run_frame(input string tag, input int ch, input logic [7:0] d,
                           input logic pbit, input logic [1:0] stops, input bit flip,
                           input int hold_low);
    rec_t exp_r, got;
    bit   is_brk, ok;
    int   brk0;
    brk0  = brk_cnt[ch];
    exp_r = model(ch, d, pbit, stops, is_brk);
    send_frame(ch, d, pbit, stops, flip);
    if (hold_low > 0) begin
      rx[ch] = 1'b0;
      repeat (hold_low * CPB) @(negedge clk);
    end
    idle(ch, 2);
    if (is_brk) begin
      chk({tag, "_brk"}, brk_cnt[ch] - brk0, 1);
      chk({tag, "_nodv"}, qsize(ch), 0);
      chk({tag, "_held"}, rxb[ch], exp_last[ch]);
    end else begin
      chk({tag, "_nbrk"}, brk_cnt[ch] - brk0, 0);
      chk({tag, "_dvcnt"}, qsize(ch), 1);
      pop(ch, got, ok);
      if (ok) begin
        chk({tag, "_byte"}, got.b, exp_r.b);
        chk({tag, "_pe"}, got.pe, exp_r.pe);
        chk({tag, "_fe"}, got.fe, exp_r.fe);
      end
      while (qsize(ch) > 0) pop(ch, got, ok);
      exp_last[ch] = d;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_dv"}, dv[k], 1'b0);
      chk({tag, "_byte"}, rxb[k], 8'h00);
      chk({tag, "_pe"}, pe[k], 1'b0);
      chk({tag, "_fe"}, fe[k], 1'b0);
      chk({tag, "_brk"}, brk[k], 1'b0);
    end
  endtask

  initial begin
    rec_t       got;
    bit         ok;
    int         b0;
    int         ch;
    logic [7:0] d;
    logic       pbit;
    logic [1:0] stops;

    for (int k = 0; k < 3; k++) begin
      brk_cnt[k]  = 0;
      exp_last[k] = 8'h00;
    end
    rst_n = 1'b0;
    rx    = 3'b111;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_quiet", qsize(0) + qsize(1) + qsize(2), 0);

    // Plain 8N1, wrong even parity, second stop bit low with the line then stuck low.
    run_frame("t1_8n1", 0, 8'hA5, 1'b0, 2'b11, 1'b0, 0);
    run_frame("t2_8e1", 1, 8'h07, 1'b0, 2'b11, 1'b0, 0);
    run_frame("t3_8n2", 2, 8'h3C, 1'b0, 2'b01, 1'b0, 3);
    run_frame("t3_after", 2, 8'hC3, 1'b0, 2'b11, 1'b0, 0);

    // Line held low for 12 bit times: one break, no DV, byte unchanged.
    b0    = brk_cnt[0];
    rx[0] = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    idle(0, 2);
    chk("t4_brk", brk_cnt[0] - b0, 1);
    chk("t4_nodv", qsize(0), 0);
    chk("t4_held", rxb[0], 8'hA5);
    run_frame("t4_55", 0, 8'h55, 1'b0, 2'b11, 1'b0, 0);

    // Short low glitch on an idle line, then a frame with one flipped sample per data bit.
    rx[0] = 1'b0;
    repeat (6) @(negedge clk);
    idle(0, 3);
    chk("t5_glitch_nodv", qsize(0), 0);
    chk("t5_glitch_nbrk", brk_cnt[0] - b0, 1);
    run_frame("t5_81", 0, 8'h81, 1'b0, 2'b11, 1'b1, 0);

    // Reset in the middle of the data bits aborts the frame.
    drive_bit(0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("t6_rst");
    rx    = 3'b111;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) exp_last[k] = 8'h00;
    idle(0, 12);
    chk("t6_nodv", qsize(0), 0);
    run_frame("t6_12", 0, 8'h12, 1'b0, 2'b11, 1'b0, 0);

    // Back-to-back frames with no idle gap.
    send_frame(0, 8'h3A, 1'b0, 2'b11, 1'b0);
    send_frame(0, 8'hC5, 1'b0, 2'b11, 1'b0);
    idle(0, 2);
    chk("b2b_cnt", qsize(0), 2);
    pop(0, got, ok);
    if (ok) chk("b2b_first", got.b, 8'h3A);
    pop(0, got, ok);
    if (ok) chk("b2b_second", got.b, 8'hC5);
    while (qsize(0) > 0) pop(0, got, ok);
    exp_last[0] = 8'hC5;

    // Randomized frames: data, parity correctness and stop bits.
    for (int n = 0; n < 24; n++) begin
      ch    = int'($urandom_range(0, 2));
      d     = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      pbit  = (^d) ^ ($urandom_range(0, 3) == 0);
      stops = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      run_frame($sformatf("rnd%0d_ch%0d", n, ch), ch, d, pbit, stops, 1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
